// File: rtl/lbist_pkg.sv
// Shared types and constants for the logic BIST controller.
// Also holds the run-latency formula used by the controller and its users.
package lbist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StShift,
    StCapture,
    StUnload,
    StCompare,
    StDone
  } lbist_state_e;

  localparam logic [15:0] DefaultPrpgPoly = 16'hB400;
  localparam logic [15:0] DefaultMisrPoly = 16'hD008;
  localparam logic [15:0] DefaultSeed     = 16'hACE1;

  // Cycles from the start-edge sampling edge to test_done going high.
  function automatic int unsigned lbist_latency(input int unsigned n_patterns,
                                                input int unsigned chain_len);
    return 3 + n_patterns * (chain_len + 1) + chain_len;
  endfunction

endpackage

// File: rtl/lbist_lfsr.sv
// Galois LFSR with a synchronous parallel load and an optional XOR-ed data input.
// The same block serves as pattern generator (din tied low) and as signature register.
module lbist_lfsr #(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY   = 16'hB400,
  parameter int unsigned      DATA_W = 1
) (
  input  logic              clk,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              step,
  input  logic [DATA_W-1:0] din,
  output logic [WIDTH-1:0]  value
);

  logic [WIDTH-1:0] value_next;

  always_comb begin
    value_next = (value << 1) ^ (value[WIDTH-1] ? POLY : '0) ^ WIDTH'(din);
  end

  // Load wins over step so a reset or re-seed always takes effect.
  always_ff @(posedge clk) begin
    if (load) begin
      value <= load_val;
    end else if (step) begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/lbist_ctrl.sv
// Logic BIST controller: drives PRPG stimulus into scan chains, compacts responses
// in a MISR and compares the final signature with a golden value.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      N_CHAINS   = 4,
  parameter int unsigned      CHAIN_LEN  = 8,
  parameter int unsigned      N_PATTERNS = 16,
  parameter logic [WIDTH-1:0] PRPG_POLY  = DefaultPrpgPoly,
  parameter logic [WIDTH-1:0] MISR_POLY  = DefaultMisrPoly,
  parameter logic [WIDTH-1:0] SEED       = DefaultSeed,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                test_start,
  output logic                test_done,
  output logic                P_F,
  output logic                busy,
  output logic                scan_en,
  output logic                capture_en,
  output logic [N_CHAINS-1:0] scan_in,
  input  logic [N_CHAINS-1:0] scan_out,
  output logic [WIDTH-1:0]    signature
);

  localparam int unsigned ShiftW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned PatW   = $clog2(N_PATTERNS + 1);
  localparam logic [ShiftW-1:0] LastShift = ShiftW'(CHAIN_LEN - 1);
  localparam logic [PatW-1:0]   NumPat    = PatW'(N_PATTERNS);

  lbist_state_e      state;
  logic              test_start_d;
  logic              armed;
  logic [ShiftW-1:0] shift_cnt;
  logic [PatW-1:0]   pat_cnt;
  logic [PatW-1:0]   pat_next;
  logic              start_edge;
  logic              run_state;
  logic              prpg_load;
  logic              prpg_step;
  logic              misr_load;
  logic              misr_step;
  logic [WIDTH-1:0]  prpg_val;
  logic [WIDTH-1:0]  misr_val;

  // armed blocks a level held high across reset from looking like a fresh edge.
  assign start_edge = test_start & ~test_start_d & armed;
  assign run_state  = (state != StIdle) && (state != StDone);
  assign pat_next   = pat_cnt + PatW'(1);

  assign prpg_load = Rst || (state == StInit);
  assign prpg_step = (state == StShift) || (state == StUnload);
  assign misr_load = Rst || (state == StInit);
  // The first load has no prior capture, so its unload data is ignored.
  assign misr_step = ((state == StShift) && (pat_cnt != '0)) || (state == StUnload);

  assign scan_in   = prpg_val[N_CHAINS-1:0];
  assign signature = misr_val;

  lbist_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (PRPG_POLY),
    .DATA_W(1)
  ) u_prpg (
    .clk     (clk),
    .load    (prpg_load),
    .load_val(SEED),
    .step    (prpg_step),
    .din     (1'b0),
    .value   (prpg_val)
  );

  lbist_lfsr #(
    .WIDTH (WIDTH),
    .POLY  (MISR_POLY),
    .DATA_W(N_CHAINS)
  ) u_misr (
    .clk     (clk),
    .load    (misr_load),
    .load_val('0),
    .step    (misr_step),
    .din     (scan_out),
    .value   (misr_val)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      state        <= StIdle;
      test_start_d <= 1'b0;
      armed        <= 1'b0;
      shift_cnt    <= '0;
      pat_cnt      <= '0;
      test_done    <= 1'b0;
      P_F          <= 1'b0;
      busy         <= 1'b0;
      scan_en      <= 1'b0;
      capture_en   <= 1'b0;
    end else begin
      test_start_d <= test_start;
      if (!test_start) begin
        armed <= 1'b1;
      end
      scan_en    <= 1'b0;
      capture_en <= 1'b0;
      if (run_state && !test_start) begin
        state     <= StIdle;
        busy      <= 1'b0;
        test_done <= 1'b0;
        P_F       <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start_edge) begin
              state <= StInit;
              busy  <= 1'b1;
            end
          end
          StInit: begin
            shift_cnt <= '0;
            pat_cnt   <= '0;
            test_done <= 1'b0;
            P_F       <= 1'b0;
            scan_en   <= 1'b1;
            state     <= StShift;
          end
          StShift: begin
            if (shift_cnt == LastShift) begin
              shift_cnt  <= '0;
              capture_en <= 1'b1;
              state      <= StCapture;
            end else begin
              shift_cnt <= shift_cnt + ShiftW'(1);
              scan_en   <= 1'b1;
            end
          end
          StCapture: begin
            pat_cnt <= pat_next;
            scan_en <= 1'b1;
            state   <= (pat_next < NumPat) ? StShift : StUnload;
          end
          StUnload: begin
            if (shift_cnt == LastShift) begin
              shift_cnt <= '0;
              state     <= StCompare;
            end else begin
              shift_cnt <= shift_cnt + ShiftW'(1);
              scan_en   <= 1'b1;
            end
          end
          StCompare: begin
            P_F   <= (misr_val == GOLDEN_SIG);
            busy  <= 1'b0;
            state <= StDone;
          end
          StDone: begin
            if (start_edge) begin
              state     <= StInit;
              busy      <= 1'b1;
              test_done <= 1'b0;
              P_F       <= 1'b0;
            end else begin
              test_done <= 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
